// File: rtl/hk_spi_bitbang.sv
// Housekeeping SPI slave (mode 0, MSB first) with a small register map.
// Register 0x13 bit-bangs the GPIO serial configuration chains.
module hk_spi_bitbang #(
  parameter logic [11:0] MFGR_ID = 12'h456,
  parameter logic [7:0]  PROD_ID = 8'h21
) (
  input  logic clock,
  input  logic resetb,
  input  logic SCK,
  input  logic CSB,
  input  logic SDI,
  output logic SDO,
  output logic sdo_enb,
  output logic serial_clock,
  output logic serial_load,
  output logic serial_resetn,
  output logic serial_data_1,
  output logic serial_data_2,
  output logic bitbang_en
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned CTRL_W = 7;

  localparam logic [BYTE_W-1:0] ADDR_BITBANG = 8'h13;
  localparam logic [BYTE_W-1:0] CMD_WR       = 8'h80;
  localparam logic [BYTE_W-1:0] CMD_RD       = 8'h40;
  localparam logic [BYTE_W-1:0] CMD_RW       = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMAND,
    ST_ADDRESS,
    ST_DATA,
    ST_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [1:0] sck_sync, csb_sync, sdi_sync;
  logic       sck_d, csb_d;
  logic       sck_s, csb_s, sdi_s;
  logic       sck_rise, sck_fall, csb_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] shreg;
  logic [BYTE_W-1:0] shift_byte;
  logic [BYTE_W-1:0] addr;
  logic [BYTE_W-1:0] sdo_shift;
  logic              wr_mode, rd_mode;
  logic [CTRL_W-1:0] reg13;

  logic cmd_done, addr_done, byte_done;
  logic last_bit;

  // Two-flop synchronizers plus previous-value flops for edge detection
  always_ff @(posedge clock) begin
    if (!resetb) begin
      sck_sync <= 2'b00;
      csb_sync <= 2'b11;
      sdi_sync <= 2'b00;
      sck_d    <= 1'b0;
      csb_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[0], SCK};
      csb_sync <= {csb_sync[0], CSB};
      sdi_sync <= {sdi_sync[0], SDI};
      sck_d    <= sck_sync[1];
      csb_d    <= csb_sync[1];
    end
  end

  assign sck_s      = sck_sync[1];
  assign csb_s      = csb_sync[1];
  assign sdi_s      = sdi_sync[1];
  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign csb_fall   = ~csb_s & csb_d;
  assign last_bit   = sck_rise && (bit_cnt == CNT_W'(7));
  assign shift_byte = {shreg, sdi_s};

  function automatic logic [BYTE_W-1:0] reg_rd(input logic [BYTE_W-1:0] a,
                                               input logic [CTRL_W-1:0] r13);
    case (a)
      8'h01:        reg_rd = {4'b0000, MFGR_ID[11:8]};
      8'h02:        reg_rd = MFGR_ID[7:0];
      8'h03:        reg_rd = PROD_ID;
      ADDR_BITBANG: reg_rd = {1'b0, r13};
      default:      reg_rd = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; byte-complete strobes still fire when CSB rises on the same cycle
  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    byte_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (csb_fall) state_nxt = ST_COMMAND;
      end
      ST_COMMAND: begin
        if (last_bit) begin
          cmd_done = 1'b1;
          if (shift_byte == CMD_WR || shift_byte == CMD_RD || shift_byte == CMD_RW)
            state_nxt = ST_ADDRESS;
          else
            state_nxt = ST_IGNORE;
        end
      end
      ST_ADDRESS: begin
        if (last_bit) begin
          addr_done = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_bit) byte_done = 1'b1;
      end
      ST_IGNORE: begin
        state_nxt = ST_IGNORE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (csb_s) state_nxt = ST_IDLE;
  end

  // Shift register, bit counter, mode and address tracking
  always_ff @(posedge clock) begin
    if (!resetb) begin
      bit_cnt <= '0;
      shreg   <= '0;
      addr    <= '0;
      wr_mode <= 1'b0;
      rd_mode <= 1'b0;
    end else begin
      if (state == ST_IDLE && csb_fall) begin
        bit_cnt <= '0;
      end else if (sck_rise && (state == ST_COMMAND || state == ST_ADDRESS || state == ST_DATA)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        shreg   <= shift_byte[BYTE_W-2:0];
      end
      if (cmd_done) begin
        wr_mode <= shift_byte[7];
        rd_mode <= shift_byte[6];
      end
      if (addr_done)      addr <= shift_byte;
      else if (byte_done) addr <= addr + BYTE_W'(1);
    end
  end

  // Only a complete byte ever reaches the control register
  always_ff @(posedge clock) begin
    if (!resetb) begin
      reg13 <= '0;
    end else if (byte_done && wr_mode && addr == ADDR_BITBANG) begin
      reg13 <= shift_byte[CTRL_W-1:0];
    end
  end

  // Read path: MSB presented when the address completes, then one bit per SCK fall;
  // a fall with bit_cnt==0 marks a byte boundary and reloads from the current address
  always_ff @(posedge clock) begin
    if (!resetb) begin
      sdo_shift <= '0;
      sdo_enb   <= 1'b1;
    end else if (csb_s) begin
      sdo_shift <= '0;
      sdo_enb   <= 1'b1;
    end else if (addr_done && rd_mode) begin
      sdo_shift <= reg_rd(shift_byte, reg13);
      sdo_enb   <= 1'b0;
    end else if (state == ST_DATA && rd_mode && sck_fall) begin
      if (bit_cnt == CNT_W'(0)) sdo_shift <= reg_rd(addr, reg13);
      else                      sdo_shift <= {sdo_shift[BYTE_W-2:0], 1'b0};
    end
  end

  assign SDO = sdo_shift[BYTE_W-1];

  // GPIO chain drive: register bits when enabled, idle levels otherwise
  always_ff @(posedge clock) begin
    if (!resetb) begin
      bitbang_en    <= 1'b0;
      serial_resetn <= 1'b1;
      serial_load   <= 1'b0;
      serial_clock  <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
    end else begin
      bitbang_en <= reg13[1];
      if (reg13[1]) begin
        serial_resetn <= reg13[2];
        serial_load   <= reg13[3];
        serial_clock  <= reg13[4];
        serial_data_1 <= reg13[5];
        serial_data_2 <= reg13[6];
      end else begin
        serial_resetn <= 1'b1;
        serial_load   <= 1'b0;
        serial_clock  <= 1'b0;
        serial_data_1 <= 1'b0;
        serial_data_2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hk_spi_bitbang.sv
// Directed bench for hk_spi_bitbang: SPI master tasks driving writes, reads and
// aborted/reset transfers, checked against hand-computed values.
module tb_hk_spi_bitbang;

  logic clock, resetb, SCK, CSB, SDI;
  logic SDO, sdo_enb;
  logic serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2, bitbang_en;

  int total = 0;
  int bad   = 0;

  hk_spi_bitbang dut (
    .clock        (clock),
    .resetb       (resetb),
    .SCK          (SCK),
    .CSB          (CSB),
    .SDI          (SDI),
    .SDO          (SDO),
    .sdo_enb      (sdo_enb),
    .serial_clock (serial_clock),
    .serial_load  (serial_load),
    .serial_resetn(serial_resetn),
    .serial_data_1(serial_data_1),
    .serial_data_2(serial_data_2),
    .bitbang_en   (bitbang_en)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Output pins packed in register-bit positions
  function automatic logic [7:0] outs();
    return {1'b0, serial_data_2, serial_data_1, serial_clock, serial_load,
            serial_resetn, bitbang_en, 1'b0};
  endfunction

  // One SPI byte (or the first nbits of it), mode 0, SCK period 200 ns
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic enb_and, output logic enb_or);
    rx = 8'h00;
    enb_and = 1'b1;
    enb_or  = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SDI = tx[i];
      #100 SCK = 1'b1;
      rx[i]   = SDO;
      enb_and = enb_and & sdo_enb;
      enb_or  = enb_or | sdo_enb;
      #100 SCK = 1'b0;
    end
  endtask

  task automatic spi_begin();
    CSB = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    #100 CSB = 1'b1;
    SDI = 1'b0;
    #400;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] v);
    logic [7:0] rx;
    logic ea, eo;
    spi_begin();
    spi_byte(8'h80, 8, rx, ea, eo);
    spi_byte(a, 8, rx, ea, eo);
    spi_byte(v, 8, rx, ea, eo);
    spi_end();
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    logic ea, eo;
    logic [7:0] rx;
    spi_begin();
    spi_byte(8'h40, 8, rx, ea, eo);
    spi_byte(a, 8, rx, ea, eo);
    spi_byte(8'h00, 8, v, ea, eo);
    spi_end();
  endtask

  logic [7:0] rx, rv;
  logic ea, eo;
  logic [7:0] exp_stream [3];

  initial begin
    resetb = 1'b0;
    CSB = 1'b1;
    SCK = 1'b0;
    SDI = 1'b0;
    repeat (5) @(negedge clock);
    check("reset_outs", outs(), 8'h04);
    check("reset_sdo", {7'd0, SDO}, 8'h00);
    check("reset_sdo_enb", {7'd0, sdo_enb}, 8'h01);
    resetb = 1'b1;
    repeat (5) @(negedge clock);

    // 1: enable with resetn and both data lines
    wr_reg(8'h13, 8'h66);
    check("wr66_outs", outs(), 8'h66);
    rd_reg(8'h13, rv);
    check("rd66", rv, 8'h66);

    // 2: serial clock toggling
    for (int p = 0; p < 2; p++) begin
      wr_reg(8'h13, 8'h16);
      check("clk_hi_outs", outs(), 8'h16);
      wr_reg(8'h13, 8'h06);
      check("clk_lo_outs", outs(), 8'h06);
    end

    // 3: load pulse
    wr_reg(8'h13, 8'h0e);
    check("load_hi_outs", outs(), 8'h0e);
    wr_reg(8'h13, 8'h06);
    check("load_lo_outs", outs(), 8'h06);

    // 4: enable clear keeps idle levels; bit 7 is not stored
    wr_reg(8'h13, 8'h60);
    check("dis_outs", outs(), 8'h04);
    rd_reg(8'h13, rv);
    check("rd60", rv, 8'h60);
    wr_reg(8'h13, 8'h81);
    check("b7_outs", outs(), 8'h04);
    rd_reg(8'h13, rv);
    check("rd_b7_dropped", rv, 8'h01);

    // read-write stream returns the old value and stores the new one
    spi_begin();
    spi_byte(8'hC0, 8, rx, ea, eo);
    spi_byte(8'h13, 8, rx, ea, eo);
    spi_byte(8'h06, 8, rx, ea, eo);
    spi_end();
    check("rw_old", rx, 8'h01);
    check("rw_outs", outs(), 8'h06);

    // unknown command is ignored
    spi_begin();
    spi_byte(8'h20, 8, rx, ea, eo);
    spi_byte(8'h13, 8, rx, ea, eo);
    spi_byte(8'h16, 8, rx, ea, eo);
    spi_end();
    check("ignore_outs", outs(), 8'h06);

    // read-only location ignores writes
    wr_reg(8'h01, 8'hAA);
    rd_reg(8'h01, rv);
    check("ro_01", rv, 8'h04);

    // 5: read stream with sdo_enb observation
    exp_stream[0] = 8'h04;
    exp_stream[1] = 8'h56;
    exp_stream[2] = 8'h21;
    check("pre_enb", {7'd0, sdo_enb}, 8'h01);
    spi_begin();
    spi_byte(8'h40, 8, rx, ea, eo);
    check("cmd_enb_hi", {7'd0, ea}, 8'h01);
    spi_byte(8'h01, 8, rx, ea, eo);
    check("addr_enb_hi", {7'd0, ea}, 8'h01);
    for (int b = 0; b < 3; b++) begin
      spi_byte(8'h00, 8, rx, ea, eo);
      check($sformatf("stream%0d", b), rx, exp_stream[b]);
      check($sformatf("stream%0d_enb_lo", b), {7'd0, eo}, 8'h00);
    end
    spi_end();
    check("post_enb", {7'd0, sdo_enb}, 8'h01);

    // address wraps 0xFF -> 0x00 -> 0x01
    spi_begin();
    spi_byte(8'h40, 8, rx, ea, eo);
    spi_byte(8'hFF, 8, rx, ea, eo);
    spi_byte(8'h00, 8, rx, ea, eo);
    check("wrap_ff", rx, 8'h00);
    spi_byte(8'h00, 8, rx, ea, eo);
    check("wrap_00", rx, 8'h00);
    spi_byte(8'h00, 8, rx, ea, eo);
    check("wrap_01", rx, 8'h04);
    spi_end();

    // 6: partial byte never written
    spi_begin();
    spi_byte(8'h80, 8, rx, ea, eo);
    spi_byte(8'h13, 8, rx, ea, eo);
    spi_byte(8'h60, 5, rx, ea, eo);
    spi_end();
    check("partial_outs", outs(), 8'h06);
    rd_reg(8'h13, rv);
    check("partial_rd", rv, 8'h06);

    // reset in the middle of a transfer
    wr_reg(8'h13, 8'h66);
    check("pre_rst_outs", outs(), 8'h66);
    spi_begin();
    spi_byte(8'h80, 8, rx, ea, eo);
    spi_byte(8'h13, 3, rx, ea, eo);
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    check("in_rst_outs", outs(), 8'h04);
    CSB = 1'b1;
    SDI = 1'b0;
    repeat (5) @(negedge clock);
    resetb = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_outs", outs(), 8'h04);
    check("post_rst_enb", {7'd0, sdo_enb}, 8'h01);
    rd_reg(8'h13, rv);
    check("post_rst_rd", rv, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hk_spi_bitbang.md
Name: hk_spi_bitbang

Overview:
- Housekeeping SPI slave (mode 0, MSB-first) with a small register map.
- Register 0x13 bit-bangs the user-project GPIO serial configuration chains: clock, load, resetn and two data lines.
- Sits between the chip housekeeping pins (SCK/CSB/SDI/SDO on mprj_io[4:1]) and the GPIO control-block shift chains.
- SPI inputs are asynchronous and are oversampled in the system clock domain.

Parameters:
- MFGR_ID, 12'h456, manufacturer ID returned at addresses 0x01/0x02.
- PROD_ID, 8'h21, product ID returned at address 0x03.

Ports:
- clock  input  1  system clock; must be at least 8x the SCK frequency.
- resetb  input  1  reset; synchronous, active-low.
- SCK  input  1  SPI clock, asynchronous.
- CSB  input  1  SPI chip select, active-low, asynchronous.
- SDI  input  1  SPI serial data in, asynchronous.
- SDO  output  1  SPI serial data out.
- sdo_enb  output  1  SDO pad output enable, active-low; 0 only while a read byte is being shifted.
- serial_clock  output  1  GPIO chain shift clock.
- serial_load  output  1  GPIO chain load strobe.
- serial_resetn  output  1  GPIO chain reset, active-low.
- serial_data_1  output  1  data into user-area-1 chain (GPIO 0 upward).
- serial_data_2  output  1  data into user-area-2 chain (GPIO 37 downward).
- bitbang_en  output  1  register 0x13 bit 1.

Behaviour:
- Input synchronisation: SCK, CSB and SDI each pass through a 2-flop synchronizer. SCK rising and falling edges are detected from the synchronized value.
- Reset (resetb=0 at a clock edge) sets:
  - register 0x13 = 0x00;
  - FSM = IDLE;
  - SDO=0, sdo_enb=1;
  - serial_* outputs to idle (clock 0, load 0, resetn 1, data 0);
  - bitbang_en=0.
- FSM states:
  - IDLE: entered on synchronized CSB=1. On CSB falling, go to COMMAND and clear the bit counter.
  - COMMAND: shift 8 bits (SDI sampled on SCK rising). Decode:
    - 0x80 write-stream;
    - 0x40 read-stream;
    - 0xC0 read-write-stream;
    - anything else: go to IGNORE until CSB rises.
  - ADDRESS: shift 8 bits into the address register.
  - DATA: repeat per byte.
    - Write modes: on the 8th rising edge the byte is written to the register at the current address.
    - Read modes: the current register value is shifted out on SDO, MSB first. Each bit is updated on the SCK falling edge (the first bit is presented immediately after the address byte completes). sdo_enb=0 during the byte.
    - Address increments by 1 (wraps 0xFF->0x00) after every data byte.
  - CSB rising in any state: return to IDLE and discard any partial byte. Registers are never written from a partial byte. sdo_enb=1.
- Register map:
  - 0x00: reads 0.
  - 0x01: {4'b0, MFGR_ID[11:8]}, read-only.
  - 0x02: MFGR_ID[7:0], read-only.
  - 0x03: PROD_ID, read-only.
  - 0x13: bit-bang control, R/W, bits[6:0] (bit 7 reads 0).
  - All other addresses read 0; writes to them are ignored.
- Register 0x13 bits:
  - 0 serial-transfer request: stored, no other effect.
  - 1 bit-bang enable.
  - 2 resetn.
  - 3 load.
  - 4 clock.
  - 5 data user 1.
  - 6 data user 2.
- Output mapping:
  - When bit1=1, the serial_* outputs equal the corresponding register bits.
  - When bit1=0, the serial_* outputs are at idle values.
  - All outputs are registered.
- Latency: a write to 0x13 appears on the outputs no later than 4 clock cycles after the synchronized 8th SCK rising edge of the data byte.
- Simultaneous events:
  - A CSB rise on the same cycle as the 8th SCK edge: the write completes.
  - Reset overrides everything.

Test Plan:
1. Reset, then write {0x80,0x13,0x66} with SCK period 200 ns and clock 20 ns. Required: bitbang_en=1, serial_resetn=1, serial_data_1=serial_data_2=1, serial_clock=0, serial_load=0. Read 0x13 back via {0x40,0x13} -> 0x66.
2. Alternate writes 0x16 / 0x06 to 0x13. Required: serial_clock toggles 1/0 once per pair; data lines 0; resetn stays 1.
3. Write 0x0e then 0x06. Required: serial_load pulses high for exactly the interval between the two writes.
4. Write 0x60 (enable bit clear). Required: outputs stay idle (resetn=1, data 0, clock 0, load 0).
5. Read stream {0x40,0x01} with 3 data bytes. Required: SDO returns 0x04, 0x56, 0x21; sdo_enb low only during the data bytes.
6. Write to 0x13 with CSB raised after 5 data bits. Required: register unchanged. Also: assert resetb=0 mid-transfer -> register 0x13=0x00, all outputs idle.
